// File: rtl/imem_debug_loader_pkg.sv
// rtl/imem_debug_loader_pkg.sv - shared constants and state encoding for the debug program loader
package imem_debug_loader_pkg;

    localparam int          P_NBITS     = 32;
    localparam int          P_CELDAS    = 256;
    localparam int          P_STEP      = 4;
    localparam logic [31:0] P_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_debug_loader_if.sv
// rtl/imem_debug_loader_if.sv - control, byte stream and memory write bus of the loader
interface imem_debug_loader_if #(
    parameter int NBITS = 32
);
    logic             i_Start;
    logic [7:0]       i_RxData;
    logic             i_RxValid;
    logic [NBITS-1:0] o_DirecDebug;
    logic [NBITS-1:0] o_DatoDebug;
    logic             o_WriteDebug;
    logic             o_Busy;
    logic             o_Done;
    logic             o_Error;
    logic [NBITS-1:0] o_WordCount;

    modport slave (
        input  i_Start, i_RxData, i_RxValid,
        output o_DirecDebug, o_DatoDebug, o_WriteDebug,
               o_Busy, o_Done, o_Error, o_WordCount
    );

    modport master (
        output i_Start, i_RxData, i_RxValid,
        input  o_DirecDebug, o_DatoDebug, o_WriteDebug,
               o_Busy, o_Done, o_Error, o_WordCount
    );
endinterface

// File: rtl/imem_debug_loader_assembler.sv
// rtl/imem_debug_loader_assembler.sv - big-endian byte to word assembler with 2-bit byte counter
module imem_debug_loader_assembler #(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [7:0]       i_byte,
    input  logic             i_valid,
    output logic [NBITS-1:0] o_word,
    output logic             o_word_ready
);

    logic [NBITS-9:0] r_shift;
    logic [1:0]       r_count;
    logic             w_take;

    // The word is presented combinationally so the FSM can latch it on the
    // same edge that accepts the fourth byte.
    assign w_take       = i_enable && i_valid;
    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = w_take && (r_count == 2'd3);

    // Shift earlier bytes toward the top; counter wraps after the fourth byte.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_shift <= '0;
            r_count <= 2'd0;
        end else if (w_take) begin
            r_shift <= o_word[NBITS-9:0];
            r_count <= r_count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_debug_loader.sv
// rtl/imem_debug_loader.sv - loads a program from the debug byte stream into instruction memory
module imem_debug_loader
    import imem_debug_loader_pkg::*;
#(
    parameter int               NBITS     = P_NBITS,
    parameter int               CELDAS    = P_CELDAS,
    parameter int               STEP      = P_STEP,
    parameter logic [NBITS-1:0] HALT_WORD = P_HALT_WORD
) (
    input  logic                i_clk,
    input  logic                i_reset,
    imem_debug_loader_if.slave  bus
);

    localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - STEP);
    localparam logic [NBITS-1:0] STEP_W    = NBITS'(STEP);

    state_t           r_state;
    logic [NBITS-1:0] r_addr;
    logic [NBITS-1:0] r_data;
    logic [NBITS-1:0] r_count;
    logic             r_write;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_start;
    logic             w_recv;
    logic             w_word_ready;
    logic [NBITS-1:0] w_word;

    // Start is honoured only while not loading; bytes only while receiving.
    assign w_start = bus.i_Start &&
                     (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
    assign w_recv  = (r_state == ST_RECV);

    imem_debug_loader_assembler #(
        .NBITS(NBITS)
    ) u_assembler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_start),
        .i_enable    (w_recv),
        .i_byte      (bus.i_RxData),
        .i_valid     (bus.i_RxValid),
        .o_word      (w_word),
        .o_word_ready(w_word_ready)
    );

    // Load sequencer: receive a word, then setup/strobe/hold the memory write.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (w_start) begin
                        r_state <= ST_RECV;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (w_word_ready) begin
                        r_data  <= w_word;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_write <= 1'b1;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    r_write <= 1'b0;
                    r_count <= r_count + NBITS'(1);
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_data == HALT_WORD) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_addr + STEP_W > LAST_ADDR) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_ERROR;
                    end else begin
                        r_addr  <= r_addr + STEP_W;
                        r_state <= ST_RECV;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_DirecDebug = r_addr;
    assign bus.o_DatoDebug  = r_data;
    assign bus.o_WriteDebug = r_write;
    assign bus.o_Busy       = r_busy;
    assign bus.o_Done       = r_done;
    assign bus.o_Error      = r_error;
    assign bus.o_WordCount  = r_count;

endmodule

// File: tb/tb_imem_debug_loader.sv
// tb/tb_imem_debug_loader.sv - self-checking bench for imem_debug_loader
module tb_imem_debug_loader;

    localparam int          STEP   = 4;
    localparam int          CELDAS = 256;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_debug_loader_if #(.NBITS(32)) bus ();

    imem_debug_loader #(
        .NBITS(32), .CELDAS(CELDAS), .STEP(STEP), .HALT_WORD(HALT)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs derived from event times (edge numbers)
    int          cyc    = 0;
    logic [31:0] e_addr = '0, e_data = '0, e_cnt = '0;
    logic        e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
    bit          pend   = 0;
    int          t_last = 0;
    logic [7:0]  m_bytes[$];
    logic [31:0] ref_mem[64];
    logic [31:0] dut_mem[64];

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            e_addr = '0; e_data = '0; e_cnt = '0;
            e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
            pend = 0;
            m_bytes.delete();
        end else begin
            if (bus.i_RxValid && pend) begin
                n_bad++;
                $display("FAIL protocol_gap: byte offered during write sequence at edge %0d", cyc);
            end
            if (bus.i_Start && !e_busy) begin
                e_busy = 1; e_done = 0; e_err = 0;
                e_addr = '0; e_cnt = '0;
                m_bytes.delete();
            end else if (bus.i_RxValid && e_busy && !pend) begin
                m_bytes.push_back(bus.i_RxData);
                if (m_bytes.size() == 4) begin
                    e_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_bytes.delete();
                    pend   = 1;
                    t_last = cyc;
                end
            end
            if (pend && cyc == t_last + 1) begin
                e_we = 1;
                ref_mem[e_addr / STEP] = e_data;
            end
            if (pend && cyc == t_last + 2) begin
                e_we  = 0;
                e_cnt = e_cnt + 1;
            end
            if (pend && cyc == t_last + 3) begin
                pend = 0;
                if (e_data == HALT) begin
                    e_done = 1; e_busy = 0;
                end else if (e_addr + STEP > CELDAS - STEP) begin
                    e_err = 1; e_busy = 0;
                end else begin
                    e_addr = e_addr + STEP;
                end
            end
        end
    end

    // Memory as the DUT actually wrote it (sampled on the strobe's rising edge)
    int          strobes = 0;
    time         strobe_time = 0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    always @(posedge bus.o_WriteDebug) begin
        dut_mem[bus.o_DirecDebug[7:2]] = bus.o_DatoDebug;
        last_wr_addr = bus.o_DirecDebug;
        last_wr_data = bus.o_DatoDebug;
        strobe_time  = $time;
        strobes++;
    end

    // Per-cycle compare against the model plus strobe stability/width checks
    logic [31:0] prev_addr = '0, prev_data = '0, hold_addr = '0, hold_data = '0;
    logic        prev_we = 0;
    bit          chk_next = 0;
    always @(negedge clk) begin
        chk("addr",  bus.o_DirecDebug, e_addr);
        chk("data",  bus.o_DatoDebug,  e_data);
        chk("we",    32'(bus.o_WriteDebug), 32'(e_we));
        chk("busy",  32'(bus.o_Busy),  32'(e_busy));
        chk("done",  32'(bus.o_Done),  32'(e_done));
        chk("error", 32'(bus.o_Error), 32'(e_err));
        chk("count", bus.o_WordCount,  e_cnt);
        if (chk_next) begin
            chk("post_addr_stable", bus.o_DirecDebug, hold_addr);
            chk("post_data_stable", bus.o_DatoDebug,  hold_data);
            chk_next = 0;
        end
        if (bus.o_WriteDebug && !prev_we) begin
            chk("pre_addr_stable", prev_addr, bus.o_DirecDebug);
            chk("pre_data_stable", prev_data, bus.o_DatoDebug);
            hold_addr = bus.o_DirecDebug;
            hold_data = bus.o_DatoDebug;
            chk_next  = 1;
        end
        if (bus.o_WriteDebug && prev_we)
            chk("we_width", 32'(1), 32'(0));
        prev_we   = bus.o_WriteDebug;
        prev_addr = bus.o_DirecDebug;
        prev_data = bus.o_DatoDebug;
    end

    // Stimulus helpers
    time last_byte_time = 0;
    bit  stray_start = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_RxData   = b;
        bus.i_RxValid  = 1'b1;
        last_byte_time = $time;
        tick();
        bus.i_RxValid  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if (stray_start && $urandom_range(0, 3) == 0) pulse_start();
                else tick();
            end
            send_byte(w[31 - 8*i -: 8]);
        end
        repeat (3 + $urandom_range(0, 2)) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        logic [31:0] w;
        int          nw;
        bus.i_Start = 1'b0; bus.i_RxValid = 1'b0; bus.i_RxData = 8'h00;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy",  32'(bus.o_Busy), 32'd0);
        chk("rst_count", bus.o_WordCount, 32'd0);

        // Test 1: reset mid-receive discards the partial word
        pulse_start();
        send_byte(8'h12); tick(); send_byte(8'h34); tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_busy", 32'(bus.o_Busy), 32'd0);
        chk("midrst_addr", bus.o_DirecDebug, 32'd0);
        chk("midrst_data", bus.o_DatoDebug, 32'd0);
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_word(32'hA1B2C3D4);
        chk("t1_wr_addr", last_wr_addr, 32'd0);
        chk("t1_wr_data", last_wr_data, 32'hA1B2C3D4);

        // Test 2: single word, strobe timing
        do_reset();
        s0 = strobes;
        pulse_start();
        send_word(32'h00220820);
        chk("t2_strobes", 32'(strobes - s0), 32'd1);
        chk("t2_wr_addr", last_wr_addr, 32'd0);
        chk("t2_wr_data", last_wr_data, 32'h00220820);
        chk("t2_latency", 32'(strobe_time - last_byte_time), 32'd19);
        chk("t2_count",   bus.o_WordCount, 32'd1);
        chk("t2_busy",    32'(bus.o_Busy), 32'd1);

        // Test 3: program plus halt word
        do_reset();
        pulse_start();
        send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
        send_word(HALT);
        chk("t3_done",    32'(bus.o_Done), 32'd1);
        chk("t3_busy",    32'(bus.o_Busy), 32'd0);
        chk("t3_count",   bus.o_WordCount, 32'd4);
        chk("t3_wr_addr", last_wr_addr, 32'd12);
        chk("t3_mem3",    dut_mem[3], HALT);
        for (int i = 0; i < 4; i++) chk("t3_mem_model", dut_mem[i], ref_mem[i]);

        // Test 5: ignored events and restart after DONE
        s0 = strobes;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        repeat (4) tick();
        chk("t5_idle_strobes", 32'(strobes - s0), 32'd0);
        chk("t5_idle_done",    32'(bus.o_Done), 32'd1);
        pulse_start();
        chk("t5_restart_done", 32'(bus.o_Done), 32'd0);
        chk("t5_restart_addr", bus.o_DirecDebug, 32'd0);
        chk("t5_restart_cnt",  bus.o_WordCount, 32'd0);
        send_byte(8'h01); send_byte(8'h02);
        pulse_start();
        send_byte(8'h03); send_byte(8'h04);
        repeat (3) tick();
        chk("t5_wr_addr", last_wr_addr, 32'd0);
        chk("t5_wr_data", last_wr_data, 32'h01020304);

        // Test 4: overflow after 64 words
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            w[31] = 1'b0;
            send_word(w);
        end
        chk("t4_error",   32'(bus.o_Error), 32'd1);
        chk("t4_done",    32'(bus.o_Done), 32'd0);
        chk("t4_count",   bus.o_WordCount, 32'd64);
        chk("t4_wr_addr", last_wr_addr, 32'd252);
        chk("t4_mem63",   dut_mem[63], ref_mem[63]);
        s0 = strobes;
        send_word(32'h12345678);
        chk("t4_extra_strobes", 32'(strobes - s0), 32'd0);

        // Randomized loads with stray starts and stray bytes
        stray_start = 1;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            pulse_start();
            nw = $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) send_word($urandom);
            if ($urandom_range(0, 1) == 1) send_word(HALT);
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
            repeat (4) tick();
            for (int i = 0; i < nw && i < 64; i++) chk("rnd_mem_model", dut_mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_debug_loader.md
Name: imem_debug_loader

Overview:
Loads a program into the instruction memory from the debug unit's serial byte stream.
- Assembles four received bytes into one 32-bit instruction.
- Drives the memory's debug address, data and write-strobe lines with a setup/strobe/hold sequence.
- Advances the word address on each write.
- Stops on the halt word 0xFFFFFFFF or when the address space is exhausted.
- Sits between the UART receiver and the instruction memory; the debug controller starts it and waits for o_Done.

Parameters:
NBITS, 32, instruction/address width
CELDAS, 256, number of instruction memory cells (byte-addressed index range)
STEP, 4, address increment per written word
HALT_WORD, 32'hFFFFFFFF, end-of-program marker (written, then load ends)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-low reset
i_Start  in  1  one-cycle pulse; begins a load at address 0
i_RxData  in  8  received byte
i_RxValid  in  1  one-cycle pulse; i_RxData valid this cycle
o_DirecDebug  out  NBITS  memory write address
o_DatoDebug  out  NBITS  memory write data
o_WriteDebug  out  1  memory write strobe (memory samples on its rising edge)
o_Busy  out  1  high from accepting i_Start until DONE/ERROR
o_Done  out  1  level, high in DONE until next i_Start
o_Error  out  1  level, high in ERROR (overflow) until next i_Start
o_WordCount  out  NBITS  words written in the current load

Behaviour:
Reset (i_reset==0 at a rising i_clk edge):
- State IDLE; all outputs 0; byte counter 0.
- Reset mid-operation aborts immediately and o_WriteDebug drops the same edge.
- Memory contents are not touched.

States: IDLE, RECV, SETUP, STROBE, HOLD, DONE, ERROR.

IDLE / DONE / ERROR:
- i_Start -> RECV. Clears the address, o_WordCount, the byte counter, o_Done and o_Error.
- i_RxValid is ignored in these states.

RECV:
- Each i_RxValid shifts i_RxData into the word: first byte = bits [31:24], big-endian.
- After the 4th byte, go to SETUP next cycle with o_DatoDebug = assembled word.
- Byte counter is 2 bits and wraps to 0.

SETUP (1 cycle):
- o_DirecDebug and o_DatoDebug stable, o_WriteDebug = 0.

STROBE (1 cycle):
- o_WriteDebug = 1. The rising edge occurs with address and data already stable one cycle.

HOLD (1 cycle):
- o_WriteDebug = 0; address and data still held.
- o_WordCount increments.
- If the word == HALT_WORD -> DONE; address not advanced.
- Else, if address + STEP > CELDAS - STEP -> ERROR.
- Else, address += STEP -> RECV.

Timing and flow control:
- Strobe occurs 2 cycles after the 4th byte is accepted.
- Word cycle = 3 cycles after the last byte.
- A byte arriving during SETUP/STROBE/HOLD is dropped, and the protocol forbids it. The UART needs ≥10 bit-times per byte, so this never happens in practice. Verification flags it via assertion, not silently.

Other rules:
- i_Start while busy (RECV..HOLD) is ignored.
- o_WriteDebug is always registered and glitch-free, and is never high for more than 1 cycle.

Address arithmetic:
- NBITS-wide, unsigned.
- Maximum valid address is CELDAS - STEP (252 with defaults).
- A write to 252 that is not the halt word -> ERROR after the write completes. The word at 252 is still written.

Decomposition:
- Shared package: state encoding localparams (IDLE..ERROR, 3 bits), HALT_WORD, STEP.
- Optional sub-module: byte_word_assembler (shift register + 2-bit counter, outputs word and word_ready pulse).
- The top-level FSM drives the memory interface.

Test Plan:
1. Reset: hold i_reset=0 two cycles mid-RECV with 2 bytes in -> all outputs 0, state IDLE; a later i_Start + 4 bytes writes to address 0 (partial word discarded).
2. Single word: i_Start, bytes 00,22,08,20 -> o_DirecDebug=0, o_DatoDebug=32'h00220820, o_WriteDebug high exactly 1 cycle, 2 cycles after 4th byte; o_WordCount=1; back in RECV.
3. Program + halt: 3 words then FF,FF,FF,FF -> writes at 0,4,8,12 (halt written at 12); o_Done=1, o_Busy=0, o_WordCount=4; memory model matches.
4. Overflow: 64 non-halt words -> last write at address 252, then o_Error=1, o_Done=0, o_WordCount=64; no strobe for extra bytes.
5. Ignored events: i_Start during RECV and i_RxValid in IDLE/DONE -> no state change, no strobe; a new i_Start after DONE clears o_Done and restarts at address 0.
6. Strobe setup check: for every o_WriteDebug rising edge, assert o_DirecDebug/o_DatoDebug were unchanged in the prior cycle and the following cycle.
